// File: rtl/multi_scale_aligner_fp16_if.sv
// Stream bundle for multi_scale_aligner_fp16: per-scale fp16 V/W inputs with
// valid/sof, the aligned output beat with valid/ready handshake, and status flags.
// The design side uses the slave modport; the stimulus side uses master.
interface multi_scale_aligner_fp16_if #(
  parameter int SCALES     = 2,
  parameter int FIFO_DEPTH = 64
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SCALES-1:0][15:0]   v_i;
  logic [SCALES-1:0][15:0]   w_i;
  logic [SCALES-1:0]         valid_i;
  logic [SCALES-1:0]         sof_i;
  logic [SCALES-1:0][15:0]   v_o;
  logic [SCALES-1:0][15:0]   w_o;
  logic [15:0]               col_o;
  logic [15:0]               row_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [SCALES-1:0]         overflow_o;
  logic                      desync_o;
  logic [SCALES-1:0][LW-1:0] level_max_o;

  modport slave (
    input  v_i, w_i, valid_i, sof_i, ready_i,
    output v_o, w_o, col_o, row_o, valid_o, overflow_o, desync_o, level_max_o
  );

  modport master (
    output v_i, w_i, valid_i, sof_i, ready_i,
    input  v_o, w_o, col_o, row_o, valid_o, overflow_o, desync_o, level_max_o
  );
endinterface

// File: rtl/multi_scale_aligner_fp16.sv
// Multi-scale fp16 V/W stream aligner. Each scale stream is registered once and
// buffered in a show-ahead FIFO; a SYNC/RUN controller discards beats until every
// scale presents a start-of-frame, then pops all scales in lockstep into one
// output register tagged with the pixel (col,row). Data passes bit-exact.
// Optional build macro MULTI_SCALE_ALIGNER_STATUS_EN enables per-scale FIFO
// high-water tracking on level_max_o; otherwise level_max_o is tied to zero.
module multi_scale_aligner_fp16 #(
  parameter int SCALES       = 2,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 64
) (
  input logic                   clk_i,
  input logic                   rst_n_i,
  multi_scale_aligner_fp16_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t state_q, state_d;

  logic [SCALES-1:0]       in_valid_q;
  logic [SCALES-1:0]       in_sof_q;
  logic [SCALES-1:0][15:0] in_v_q;
  logic [SCALES-1:0][15:0] in_w_q;

  logic [32:0]             mem [SCALES][FIFO_DEPTH];
  logic [SCALES-1:0][AW:0] wr_ptr, rd_ptr, count;
  logic [SCALES-1:0][32:0] head;
  logic [SCALES-1:0]       empty, full, head_sof, pop, wr_en, ovf_set;

  logic [15:0]             col_cnt, row_cnt;
  logic                    load, desync_set, frame_last, all_ready, all_sof, any_sof;

  logic [SCALES-1:0][15:0] v_q, w_q;
  logic [15:0]             col_q, row_q;
  logic                    valid_q;
  logic [SCALES-1:0]       overflow_q;
  logic                    desync_q;

  // Input capture stage: one register on every per-scale input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_valid_q <= '0;
      in_sof_q   <= '0;
      in_v_q     <= '0;
      in_w_q     <= '0;
    end else begin
      in_valid_q <= bus.valid_i;
      in_sof_q   <= bus.sof_i;
      in_v_q     <= bus.v_i;
      in_w_q     <= bus.w_i;
    end
  end

  // FIFO status, show-ahead heads and write qualification.
  // A full FIFO still accepts a write when it is popped in the same cycle.
  always_comb begin
    for (int unsigned s = 0; s < SCALES; s++) begin
      count[s]    = wr_ptr[s] - rd_ptr[s];
      empty[s]    = (count[s] == '0);
      full[s]     = count[s][AW];
      head[s]     = mem[s][rd_ptr[s][AW-1:0]];
      head_sof[s] = head[s][32];
      wr_en[s]    = in_valid_q[s] && (!full[s] || pop[s]);
      ovf_set[s]  = in_valid_q[s] && full[s] && !pop[s];
    end
  end

  // FIFO storage write port (no reset on the array itself).
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < SCALES; s++) begin
      if (wr_en[s]) mem[s][wr_ptr[s][AW-1:0]] <= {in_sof_q[s], in_v_q[s], in_w_q[s]};
    end
  end

  // FIFO pointers and sticky overflow flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= '0;
    end else begin
      for (int unsigned s = 0; s < SCALES; s++) begin
        if (wr_en[s])   wr_ptr[s]     <= wr_ptr[s] + PTR_ONE;
        if (pop[s])     rd_ptr[s]     <= rd_ptr[s] + PTR_ONE;
        if (ovf_set[s]) overflow_q[s] <= 1'b1;
      end
    end
  end

  // Controller next state: SYNC flushes non-sof heads, RUN pops all scales together.
  always_comb begin
    state_d    = state_q;
    pop        = '0;
    load       = 1'b0;
    desync_set = 1'b0;
    all_ready  = ~|empty;
    all_sof    = all_ready && (&head_sof);
    any_sof    = |(head_sof & ~empty);
    frame_last = (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    case (state_q)
      SYNC: begin
        pop = ~empty & ~head_sof;
        if (all_sof) state_d = RUN;
      end
      RUN: begin
        if (((col_cnt != '0) || (row_cnt != '0)) && any_sof) begin
          desync_set = 1'b1;
          state_d    = SYNC;
        end else if (all_ready && (bus.ready_i || !valid_q)) begin
          load = 1'b1;
          pop  = '1;
          if (frame_last) state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= SYNC;
    else          state_q <= state_d;
  end

  // Output register, pixel counters and sticky desync flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q      <= '0;
      w_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      desync_q <= 1'b0;
    end else begin
      if (load) begin
        for (int unsigned s = 0; s < SCALES; s++) begin
          v_q[s] <= head[s][31:16];
          w_q[s] <= head[s][15:0];
        end
        col_q   <= col_cnt;
        row_q   <= row_cnt;
        valid_q <= 1'b1;
        if (frame_last) begin
          col_cnt <= '0;
          row_cnt <= '0;
        end else if (col_cnt == COL_LAST) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 16'd1;
        end else begin
          col_cnt <= col_cnt + 16'd1;
        end
      end else if (bus.ready_i) begin
        valid_q <= 1'b0;
      end
      if (desync_set) begin
        desync_q <= 1'b1;
        col_cnt  <= '0;
        row_cnt  <= '0;
      end
    end
  end

  assign bus.v_o        = v_q;
  assign bus.w_o        = w_q;
  assign bus.col_o      = col_q;
  assign bus.row_o      = row_q;
  assign bus.valid_o    = valid_q;
  assign bus.overflow_o = overflow_q;
  assign bus.desync_o   = desync_q;

`ifdef MULTI_SCALE_ALIGNER_STATUS_EN
  logic [SCALES-1:0][LW-1:0] level_max_q;

  // Peak FIFO occupancy per scale since reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_max_q <= '0;
    end else begin
      for (int unsigned s = 0; s < SCALES; s++) begin
        if (count[s] > level_max_q[s]) level_max_q[s] <= count[s];
      end
    end
  end

  assign bus.level_max_o = level_max_q;
`else
  assign bus.level_max_o = '0;
`endif
endmodule

// File: tb/tb_multi_scale_aligner_fp16.sv
// Scoreboard bench for multi_scale_aligner_fp16 (SCALES=2, 4x2 image, depth 16).
// A beat-level reference model turns issued beats into expected output beats;
// a negedge monitor pops and compares every accepted output and checks that
// stalled outputs hold steady.
module tb_multi_scale_aligner_fp16;
  localparam int NS = 2;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 16;

  typedef struct packed { logic sof; logic [15:0] v; logic [15:0] w; } beat_t;
  typedef struct packed { logic vld; beat_t b; } slot_t;
  typedef struct packed { logic [15:0] v0, w0, v1, w1, col, row; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_scale_aligner_fp16_if #(.SCALES(NS), .FIFO_DEPTH(D)) bus ();

  multi_scale_aligner_fp16 #(
    .SCALES(NS), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FIFO_DEPTH(D)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  slot_t sq[NS][$];
  logic  rq[$];
  beat_t mq[NS][$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  bit    m_run = 0;
  int    m_cnt = 0;
  bit    m_desync = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: align streams beat by beat from the frame rules alone.
  function automatic void model_step();
    bit    progress;
    beat_t a, b;
    exp_t  e;
    progress = 1;
    while (progress) begin
      progress = 0;
      if (!m_run) begin
        for (int s = 0; s < NS; s++)
          while (mq[s].size() > 0 && !mq[s][0].sof) void'(mq[s].pop_front());
        if (mq[0].size() > 0 && mq[1].size() > 0) begin
          m_run = 1; m_cnt = 0; progress = 1;
        end
      end else if (m_cnt != 0 && ((mq[0].size() > 0 && mq[0][0].sof) ||
                                  (mq[1].size() > 0 && mq[1][0].sof))) begin
        m_desync = 1; m_run = 0; m_cnt = 0; progress = 1;
      end else if (mq[0].size() > 0 && mq[1].size() > 0) begin
        a = mq[0].pop_front();
        b = mq[1].pop_front();
        e.v0 = a.v; e.w0 = a.w; e.v1 = b.v; e.w1 = b.w;
        e.col = 16'(m_cnt % W);
        e.row = 16'(m_cnt / W);
        sb.push_back(e);
        m_cnt++;
        if (m_cnt == W * H) begin m_run = 0; m_cnt = 0; end
        progress = 1;
      end
    end
  endfunction

  task automatic add_beats(input int s, input int n, input bit first_sof);
    slot_t sl;
    for (int i = 0; i < n; i++) begin
      sl.vld   = 1'b1;
      sl.b.sof = first_sof && (i == 0);
      sl.b.v   = 16'($urandom);
      sl.b.w   = 16'($urandom);
      sq[s].push_back(sl);
    end
  endtask

  task automatic add_idle(input int s, input int n);
    for (int i = 0; i < n; i++) sq[s].push_back('0);
  endtask

  task automatic run_stim();
    slot_t sl;
    while (sq[0].size() > 0 || sq[1].size() > 0 || rq.size() > 0) begin
      for (int s = 0; s < NS; s++) begin
        sl = (sq[s].size() > 0) ? sq[s].pop_front() : '0;
        bus.valid_i[s] = sl.vld;
        bus.sof_i[s]   = sl.b.sof;
        bus.v_i[s]     = sl.b.v;
        bus.w_i[s]     = sl.b.w;
        if (sl.vld) mq[s].push_back(sl.b);
      end
      model_step();
      bus.ready_i = (rq.size() > 0) ? rq.pop_front() : 1'b1;
      @(posedge clk); #1;
    end
    bus.valid_i = '0;
    bus.sof_i   = '0;
    bus.ready_i = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((sb.size() > 0 || bus.valid_o) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare accepted beats and check that stalled outputs hold.
  initial begin
    exp_t e, prev;
    bit   stalled;
    stalled = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
      end else begin
        e = {bus.v_o[0], bus.w_o[0], bus.v_o[1], bus.w_o[1], bus.col_o, bus.row_o};
        if (stalled) begin
          chk("stall_hold_valid", 64'(bus.valid_o), 64'd1);
          chk("stall_hold_data", 64'(e.v0 ^ prev.v0 ^ e.w1 ^ prev.w1) | 64'(e.col ^ prev.col), 64'd0);
        end
        if (bus.valid_o && bus.ready_i) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got col=%0d row=%0d required no beat", e.col, e.row);
          end else if (e !== sb[0]) begin
            errors++;
            $display("FAIL out_beat: got %h required %h", e, sb[0]);
            void'(sb.pop_front());
          end else begin
            void'(sb.pop_front());
          end
        end
        stalled = bus.valid_o && !bus.ready_i;
        prev = e;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    bus.valid_i = '0;
    bus.sof_i   = '0;
    bus.v_i     = '0;
    bus.w_i     = '0;
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_colrow", 64'({bus.col_o, bus.row_o}), 64'd0);
    chk("rst_flags", 64'({bus.overflow_o, bus.desync_o}), 64'd0);
    chk("rst_level", 64'(bus.level_max_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Lockstep frames with ready held high.
    add_beats(0, 8, 1); add_beats(0, 8, 1);
    add_beats(1, 8, 1); add_beats(1, 8, 1);
    run_stim();
    drain("lockstep");

    // Latency through empty FIFOs while running, then a 5-cycle stall.
    add_beats(0, 1, 1); add_beats(1, 1, 1);
    run_stim();
    repeat (8) @(posedge clk);
    #1;
    add_beats(0, 1, 0); add_beats(1, 1, 0);
    run_stim();
    @(negedge clk);
    @(negedge clk);
    chk("latency_cycle2", 64'(bus.valid_o), 64'd0);
    @(negedge clk);
    chk("latency_cycle3", 64'(bus.valid_o), 64'd1);
    @(posedge clk); #1;
    add_beats(0, 6, 0); add_beats(1, 6, 0);
    rq.push_back(1'b1); rq.push_back(1'b1);
    for (int i = 0; i < 5; i++) rq.push_back(1'b0);
    run_stim();
    drain("stall");

    // Scale 1 delayed by 10 cycles, random back-pressure.
    add_beats(0, 8, 1); add_beats(0, 8, 1);
    add_idle(1, 10); add_beats(1, 8, 1); add_beats(1, 8, 1);
    for (int i = 0; i < 30; i++) rq.push_back($urandom_range(0, 3) != 0);
    run_stim();
    drain("delayed");
`ifdef MULTI_SCALE_ALIGNER_STATUS_EN
    chk("level_max_ge10", 64'(bus.level_max_o[0] >= 10), 64'd1);
`else
    chk("level_max_tied", 64'(bus.level_max_o), 64'd0);
`endif

    // Stale beats ahead of the frame start on scale 0.
    add_beats(0, 3, 0); add_beats(0, 8, 1);
    add_idle(1, 3); add_beats(1, 8, 1);
    run_stim();
    drain("stale");
    chk("no_desync_yet", 64'(bus.desync_o), 64'd0);

    // Early sof on scale 1 at col=2, then realignment.
    add_beats(0, 8, 1); add_beats(0, 8, 1);
    add_beats(1, 2, 1); add_beats(1, 8, 1);
    run_stim();
    drain("desync");
    chk("desync_flag", 64'(bus.desync_o), 64'(m_desync));
    chk("desync_set", 64'(bus.desync_o), 64'd1);
    chk("no_overflow", 64'(bus.overflow_o), 64'd0);

    // Asynchronous reset mid-frame.
    add_beats(0, 3, 1); add_beats(1, 3, 1);
    run_stim();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(bus.valid_o), 64'd0);
    chk("async_colrow", 64'({bus.col_o, bus.row_o}), 64'd0);
    chk("async_data", 64'({bus.v_o, bus.w_o}), 64'd0);
    chk("async_flags", 64'({bus.overflow_o, bus.desync_o}), 64'd0);
    chk("async_level", 64'(bus.level_max_o), 64'd0);
    sb.delete();
    for (int s = 0; s < NS; s++) mq[s].delete();
    m_run = 0; m_cnt = 0; m_desync = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add_beats(0, 8, 1); add_beats(1, 8, 1);
    run_stim();
    drain("post_reset");

    // Overflow: only scale 0 streams, so nothing pops; 17th beat is dropped.
    add_beats(0, D, 1);
    run_stim();
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_not_yet", 64'(bus.overflow_o), 64'd0);
    add_beats(0, 1, 0);
    run_stim();
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_set", 64'(bus.overflow_o), 64'b01);
`ifdef MULTI_SCALE_ALIGNER_STATUS_EN
    chk("ovf_level", 64'(bus.level_max_o[0]), 64'(D));
`endif
    chk("ovf_no_output", 64'(bus.valid_o), 64'd0);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_scale_aligner_fp16.md
MULTI_SCALE_ALIGNER_FP16 -- requirements
Module: multi_scale_aligner_fp16

Interface
REQ-001 SHALL have parameter SCALES, default 2, number of scale streams aligned (legal 2..8).
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, pixels per row.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 480, rows per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64, entries per scale FIFO (power of 2, >=4).
REQ-005 SHALL have port clk_i  in  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port rst_n_i  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports v_i[SCALES], w_i[SCALES]  in  16 each  fp16 V/W per scale.
REQ-008 SHALL have ports valid_i[SCALES], sof_i[SCALES]  in  1 each  per-scale beat valid and start-of-frame marker.
REQ-009 SHALL have ports v_o[SCALES], w_o[SCALES]  out  16 each  aligned fp16 V/W.
REQ-010 SHALL have ports col_o, row_o  out  16  pixel coordinate of the output beat.
REQ-011 SHALL have ports valid_o out 1 and ready_i in 1, output valid/ready handshake.
REQ-012 SHALL have ports overflow_o[SCALES] out 1 and desync_o out 1, sticky error flags.
REQ-013 SHALL have ports level_max_o[SCALES]  out  $clog2(FIFO_DEPTH)+1  FIFO high-water mark.

Function
REQ-014 SHALL register all inputs once before the FIFOs; data is passed bit-exact, with no arithmetic on fp16 values.
REQ-015 SHALL hold one show-ahead FIFO per scale storing {sof, v, w}, written when the registered valid is high.
REQ-016 SHALL, on a write to a full FIFO, drop the beat and set overflow_o[s] until reset.
REQ-017 SHALL implement FSM states SYNC and RUN.
REQ-018 In SYNC, SHALL pop and discard the head of each non-empty FIFO whose head sof=0.
REQ-019 In SYNC, SHALL move to RUN once every FIFO is non-empty with head sof=1, without popping in that cycle.
REQ-020 In RUN, SHALL pop all FIFOs together and load the output register only when all are non-empty and (ready_i=1 or valid_o=0).
REQ-021 SHALL hold v_o/w_o/col_o/row_o/valid_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL drop valid_o after an accepted beat when no new beat is loaded in the same cycle.
REQ-023 SHALL give (col,row)=(0,0) to the first beat after SYNC, increment col per loaded beat, and wrap col at IMAGE_WIDTH-1 to 0 with row+1.
REQ-024 SHALL, after loading beat (IMAGE_WIDTH-1, IMAGE_HEIGHT-1), return to SYNC with the counters cleared.
REQ-025 SHALL, in RUN with the counters not at (0,0), treat any FIFO head with sof=1 as a desync: set desync_o (sticky), go to SYNC, and pop nothing that cycle.
REQ-026 SHALL load at most one beat per cycle; a load and ready_i acceptance in the same cycle is legal (full throughput).
REQ-027 SHALL have a latency of 3 cycles: beats presented with valid_i in cycle 0 to empty FIFOs in RUN appear with valid_o=1 in cycle 3.
REQ-028 SHALL accept simultaneous FIFO write and pop on the same scale in one cycle, including when the FIFO is full.

Reset
REQ-029 SHALL, on rst_n_i low, asynchronously clear FIFO pointers, FSM to SYNC, col_o/row_o to 0, valid_o to 0, v_o/w_o to 0, overflow_o/desync_o to 0, and level_max_o to 0.
REQ-030 SHALL discard any partial frame on reset assertion mid-operation and resume in SYNC after release.

Configuration
REQ-031 SHALL, with macro MULTI_SCALE_ALIGNER_STATUS_EN defined, drive level_max_o[s] as the peak FIFO occupancy since reset.
REQ-032 SHALL, without MULTI_SCALE_ALIGNER_STATUS_EN, tie level_max_o to 0 and implement no tracking logic; all other behaviour is identical.

Verification
REQ-033 SCALES=2, W=4, H=2, both scales in lockstep with sof on the first beat, ready_i=1 -> 8 beats out with col/row 0..3/0..1, first valid_o 3 cycles after the first input.
REQ-034 Scale 1 delayed 10 cycles vs scale 0 -> outputs pair beat n of scale 0 with beat n of scale 1 exactly; level_max_o[0]>=10 with the macro.
REQ-035 3 stale sof=0 beats on scale 0 before its sof -> discarded in SYNC; the first output carries the sof beats, col=0 row=0.
REQ-036 ready_i held low 5 cycles mid-frame -> outputs frozen, no beat lost or duplicated; the FIFO_DEPTH+1 beat into a stalled FIFO sets overflow_o[s].
REQ-037 sof on scale 1 at col=2 mid-frame -> desync_o=1, FSM to SYNC, realignment on the next common sof.
REQ-038 rst_n_i pulsed low mid-frame -> all outputs 0 immediately (asynchronous), next frame aligned normally.
